// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and a
// FIFO of completed mul/div results, and tracks busy destinations for the
// hazard unit.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_reg_write,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        sb_stall,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [4:0]       fifo_rd   [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy;
  logic [31:0]      busy_nxt;

  logic pipe_own;
  logic fifo_pop;
  logic md_accept;
  logic fifo_push;

  // Port ownership, FIFO handshake and push/pop decisions
  always_comb begin
    pipe_own  = pipe_reg_write && (pipe_rd != 5'd0);
    fifo_pop  = reset && !pipe_own && (count != '0);
    md_ready  = reset && (count < CNT_W'(FIFO_DEPTH));
    md_accept = md_valid && md_ready;
    fifo_push = md_accept && (md_rd != 5'd0);
  end

  // Write-port mux: pipeline first, then FIFO head, otherwise idle zeros
  always_comb begin
    wb_reg_write = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    if (reset) begin
      if (pipe_own) begin
        wb_reg_write = 1'b1;
        wb_rd        = pipe_rd;
        wb_data      = pipe_data;
      end else if (count != '0) begin
        wb_reg_write = 1'b1;
        wb_rd        = fifo_rd[head];
        wb_data      = fifo_data[head];
      end
    end
  end

  // Result storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_rd[tail]   <= md_rd;
      fifo_data[tail] <= md_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fifo_push) tail <= tail + PTR_W'(1);
      if (fifo_pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  // Scoreboard update: clear on write-back of a buffered result, set on issue (set wins)
  always_comb begin
    busy_nxt = busy;
    if (fifo_pop) busy_nxt[fifo_rd[head]] = 1'b0;
    if (md_issue && (md_issue_rd != 5'd0)) busy_nxt[md_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Stall decode when any checked register awaits a mul/div result
  always_comb begin
    sb_stall = reset && (busy[chk_rs1] || busy[chk_rs2] || busy[chk_rd]);
  end

endmodule
